// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy counter, threshold flags
// and sticky overflow/underflow error flags.
module param_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 W_INC,
  input  logic [WIDTH-1:0]     WR_DATA,
  input  logic                 R_INC,
  input  logic                 CLR_ERR,
  output logic [WIDTH-1:0]     RD_DATA,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 ALMOST_FULL,
  output logic                 ALMOST_EMPTY,
  output logic [PTR_WIDTH:0]   FILL_LEVEL,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_L = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_L    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_L    = (PTR_WIDTH+1)'(AE_THRESH);

  // Handshake: a write is accepted on an edge where W_INC=1 and FULL=0; a read
  // is accepted where R_INC=1 and EMPTY=0. Both may be accepted on the same edge.
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wptr;
  logic [PTR_WIDTH-1:0] r_rptr;
  logic [PTR_WIDTH:0]   r_fill;
  logic [WIDTH-1:0]     r_rd_data;
  logic                 r_ovf;
  logic                 r_unf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_full   = (r_fill == DEPTH_L);
  assign w_empty  = (r_fill == '0);
  assign w_wr_acc = W_INC & ~w_full;
  assign w_rd_acc = R_INC & ~w_empty;

  // A rejected request paired with an accepted opposite operation is not an error:
  // the FIFO still makes progress, so only a lone blocked request flags.
  assign w_ovf_evt = W_INC & w_full  & ~R_INC;
  assign w_unf_evt = R_INC & w_empty & ~W_INC;

  always_ff @(posedge CLK) begin
    if (w_wr_acc) r_mem[r_wptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_fill    <= '0;
      r_rd_data <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      // Set has priority over clear so an error coinciding with CLR_ERR is kept.
      if (w_ovf_evt)    r_ovf <= 1'b1;
      else if (CLR_ERR) r_ovf <= 1'b0;
      if (w_unf_evt)    r_unf <= 1'b1;
      else if (CLR_ERR) r_unf <= 1'b0;
    end
  end

  assign RD_DATA      = r_rd_data;
  assign FILL_LEVEL   = r_fill;
  assign FULL         = w_full;
  assign EMPTY        = w_empty;
  assign ALMOST_FULL  = (r_fill >= AF_L);
  assign ALMOST_EMPTY = (r_fill <= AE_L);
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_unf;

endmodule
